arr_drv: RTL
============

# arr_drv

Stimulus source for the `arr` checker array: drives a `sig0`/`sig1` vector pair per accepted cycle from a programmable pattern generator, with optional single-vector error injection on `sig1`. Bursts are started by the simulation-control layer, or by Python via public signals. Each burst runs for a programmed vector count and ends with a done pulse. Sits beside `duv` and feeds one `arr` instance (or a broadcast to many), giving the checker's compare path a defined writer.

## Interface
Parameters:
- `LENGTH`, default 1 — vector width, legal range 1..255, matches the target `arr` `LENGTH`.
- `CNT_W`, default 16 — width of burst count, inject index and sent counter.

Ports:
- `arr_drv_clk_ip`, input, 1 — the single clock.
- `arr_drv_rst_ip`, input, 1 — reset, synchronous, active-high.
- `arr_drv_start_ip`, input, 1 — burst start request; sampled only in IDLE.
- `arr_drv_mode_ip`, input, 2 — pattern select, captured at start.
- `arr_drv_count_ip`, input, `CNT_W` — vectors in the burst, captured at start.
- `arr_drv_inject_en_ip`, input, 1 — enable error injection, captured at start.
- `arr_drv_inject_ip`, input, `CNT_W` — vector index to corrupt, captured at start.
- `arr_drv_ready_ip`, input, 1 — consumer ready; tie high for `arr`.
- `arr_drv_valid_op`, output, 1 — vector pair valid.
- `arr_drv_sig0_op`, output, `LENGTH` — reference vector.
- `arr_drv_sig1_op`, output, `LENGTH` — compare vector.
- `arr_drv_busy_op`, output, 1 — state is not IDLE.
- `arr_drv_done_op`, output, 1 — one-cycle end-of-burst pulse.
- `arr_drv_sent_op`, output, `CNT_W` — handshakes completed in the current or last burst.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - On `start`, capture mode, count, inject_en and inject.
  - Clear the index, the sent counter and the walking position; reload the LFSR seed.
  - Go to DONE if count==0, else go to RUN.
- **RUN:**
  - `valid`=1.
  - On `valid & ready`: increment index and sent, then load the next vector.
  - If that handshake had index==count-1, go to DONE and drop `valid` in the same transition.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **`start` outside IDLE:** ignored; no queuing.
- **Patterns** (`sig0`, for vector index n):
  - Mode 0, counter: n zero-extended or truncated to `LENGTH`.
  - Mode 1, walking one: bit (n mod `LENGTH`) set. Uses a position counter wrapping at `LENGTH`-1, never a divider. For `LENGTH`=1 the output is always 1.
  - Mode 2, LFSR: 32-bit Galois LFSR, polynomial 0x80200003, seed 0xFFFFFFFF. Advances once per handshake. The 32-bit state is replicated MSB-ward and truncated to `LENGTH`.
  - Mode 3, alternating: all-zeros when n is even, all-ones when n is odd.
- **sig1:**
  - Normally `sig1` = `sig0`.
  - If inject_en and n==inject: `sig1` = `sig0` with bit 0 inverted, for that vector only.
  - If inject ≥ count, no corruption occurs.
- **Counters:** index and sent wrap modulo 2^`CNT_W`; the maximum burst is 2^`CNT_W`-1.

## Timing
- All outputs are registered.
- **Reset values:** `valid` 0, `sig0`/`sig1` 0, `busy` 0, `done` 0, `sent` 0, state IDLE, LFSR seed.
- **Start latency:** `start` sampled at edge t gives `valid`=1 with vector 0 after edge t+1.
- **Throughput:** with `ready` held high, one vector per cycle.
- **Back-pressure:** while `valid & !ready`, `sig0`, `sig1` and `sent` hold.
- **End of burst:** the final handshake at edge k gives `valid`=0 and `done`=1 after k+1, and `busy`=0 after k+2.
- **count==0:** `done` one cycle after start, with `valid` never asserted.
- **Reset mid-burst:** all outputs return to reset values at the next edge. No `done` pulse. Reset has priority over `start`.

## Structure
- **Package `arr_drv_pkg`:**
  - State enum (IDLE, RUN, DONE).
  - Mode encoding constants (COUNT=0, WALK=1, LFSR=2, ALT=3).
  - LFSR polynomial and seed constants.
- **Sub-module `arr_drv_lfsr`:** 32-bit Galois LFSR with load and advance controls.
- **Top level:** FSM, counters, pattern mux, injection.

## Test plan
- **Counter, no back-pressure:** `LENGTH`=8, mode 0, count=4, ready=1 → `sig0`=`sig1`=00,01,02,03 on consecutive cycles; `done` one cycle later; `sent`=4.
- **Walking one with injection:** `LENGTH`=3, mode 1, count=5, inject_en=1, inject=2 → `sig0`=1,2,4,1,2; `sig1`=1,2,5,1,2; a connected `arr` reports exactly one error.
- **Back-pressure:** mode 3, count=3, ready low for 2 cycles at vector 1 → `sig0`=FF held for 3 cycles, then 00; `sent` ends at 3.
- **count==0 and ignored start:** count=0 → `done` at t+1 and `valid` never set. A second `start` pulsed while `busy` → ignored.
- **LFSR:** `LENGTH`=40, mode 2, count=2 → vector 0 = FF_FFFFFFFF; vector 1 = replicated next LFSR state per polynomial 0x80200003.
- **Reset mid-burst:** count=10, reset asserted at vector 4 → next cycle `valid`=0, `busy`=0, `sent`=0, no `done`; a new start restarts from vector 0.

Source files
------------

// File: rtl/arr_drv_pkg.sv
// arr_drv_pkg: shared types and constants for the arr_drv stimulus source.
//   state_t      - burst FSM state (IDLE, RUN, DONE)
//   MODE_*       - pattern select encodings on arr_drv_mode_ip
//   LFSR_POLY    - Galois feedback mask; the register shifts left and, when
//                  the bit shifted out of bit 31 is 1, XORs this mask in
//   LFSR_SEED    - value loaded at reset and at every burst start
package arr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

endpackage

// File: rtl/arr_drv_if.sv
// arr_drv_if: bundle of the arr_drv control and vector-stream signals.
//   start/mode/count/inject_en/inject - burst setup, sampled in IDLE
//   valid/ready                       - vector stream handshake
//   sig0/sig1                         - reference and compare vectors
//   busy/done/sent                    - burst status
//   state                             - FSM state, for observation only
// Handshake: a vector transfers on every clock edge where valid and ready
// are both high; while valid is high and ready is low, sig0, sig1 and sent
// hold, and valid stays high until the transfer happens.
// Modports: master = the driver (arr_drv), slave = whoever controls it and
// consumes the vectors.
interface arr_drv_if
  import arr_drv_pkg::*;
#(
  parameter int LENGTH = 1,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  count;
  logic              inject_en;
  logic [CNT_W-1:0]  inject;
  logic              ready;
  logic              valid;
  logic [LENGTH-1:0] sig0;
  logic [LENGTH-1:0] sig1;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sent;
  state_t            state;

  modport master (
    input  start, mode, count, inject_en, inject, ready,
    output valid, sig0, sig1, busy, done, sent, state
  );

  modport slave (
    output start, mode, count, inject_en, inject, ready,
    input  valid, sig0, sig1, busy, done, sent, state
  );
endinterface

// File: rtl/arr_drv_lfsr.sv
// arr_drv_lfsr: 32-bit left-shifting Galois LFSR.
//   clk_i, rst_i - clock, synchronous active-high reset (loads the seed)
//   load_i       - reload the seed (takes priority over adv_i)
//   adv_i        - step once
//   next_o       - value the register takes on the next step; the top uses
//                  it to build the vector that follows a handshake
module arr_drv_lfsr
  import arr_drv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] next_o
);
  logic [31:0] state_q;
  logic [31:0] state_d;

  assign next_o = {state_q[30:0], 1'b0} ^ (state_q[31] ? LFSR_POLY : 32'd0);

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = LFSR_SEED;
    end else if (adv_i) begin
      state_d = next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/arr_drv.sv
// arr_drv: burst stimulus source for the arr checker array.
// A start in IDLE captures the burst setup and loads vector 0; each
// valid&ready transfer then loads the next vector until count vectors have
// gone out, followed by a one-cycle done pulse.
// Ports:
//   arr_drv_clk_ip / arr_drv_rst_ip     - clock, synchronous active-high reset
//   arr_drv_start_ip, _mode_ip, _count_ip, _inject_en_ip, _inject_ip
//                                       - burst setup, sampled only in IDLE
//   arr_drv_ready_ip / arr_drv_valid_op - vector handshake
//   arr_drv_sig0_op / arr_drv_sig1_op   - reference / compare vectors
//   arr_drv_busy_op, _done_op, _sent_op - burst status
//   arr_drv_state_op                    - FSM state for observation
module arr_drv
  import arr_drv_pkg::*;
#(
  parameter int LENGTH = 1,
  parameter int CNT_W  = 16
) (
  input  logic              arr_drv_clk_ip,
  input  logic              arr_drv_rst_ip,
  input  logic              arr_drv_start_ip,
  input  logic [1:0]        arr_drv_mode_ip,
  input  logic [CNT_W-1:0]  arr_drv_count_ip,
  input  logic              arr_drv_inject_en_ip,
  input  logic [CNT_W-1:0]  arr_drv_inject_ip,
  input  logic              arr_drv_ready_ip,
  output logic              arr_drv_valid_op,
  output logic [LENGTH-1:0] arr_drv_sig0_op,
  output logic [LENGTH-1:0] arr_drv_sig1_op,
  output logic              arr_drv_busy_op,
  output logic              arr_drv_done_op,
  output logic [CNT_W-1:0]  arr_drv_sent_op,
  output state_t            arr_drv_state_op
);
  state_t            state_q,  state_d;
  logic [1:0]        mode_q,   mode_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              inj_en_q, inj_en_d;
  logic [CNT_W-1:0]  inj_q,    inj_d;
  logic [CNT_W-1:0]  idx_q,    idx_d;
  logic [CNT_W-1:0]  sent_q,   sent_d;
  logic [7:0]        pos_q,    pos_d;
  logic [LENGTH-1:0] sig0_q,   sig0_d;
  logic [LENGTH-1:0] sig1_q,   sig1_d;
  logic              valid_q,  valid_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic        hs;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic [31:0] lfsr_next;

  // Vector for index n. pos is the walking-one position (n mod LENGTH,
  // kept by a wrapping counter); lf is the LFSR state for this index,
  // repeated every 32 bits up to LENGTH.
  function automatic logic [LENGTH-1:0] pattern(
    input logic [1:0]       m,
    input logic [CNT_W-1:0] n,
    input logic [7:0]       pos,
    input logic [31:0]      lf
  );
    logic [LENGTH+CNT_W-1:0] ext;
    logic [LENGTH-1:0]       v;
    ext = {{LENGTH{1'b0}}, n};
    v   = '0;
    case (m)
      MODE_COUNT: v = ext[LENGTH-1:0];
      MODE_WALK:  v = LENGTH'(1) << pos;
      MODE_LFSR:  for (int i = 0; i < LENGTH; i++) v[i] = lf[i[4:0]];
      default:    v = {LENGTH{n[0]}};
    endcase
    return v;
  endfunction

  arr_drv_lfsr u_lfsr (
    .clk_i  (arr_drv_clk_ip),
    .rst_i  (arr_drv_rst_ip),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .next_o (lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    inj_en_d  = inj_en_q;
    inj_d     = inj_q;
    idx_d     = idx_q;
    sent_d    = sent_q;
    pos_d     = pos_q;
    sig0_d    = sig0_q;
    sig1_d    = sig1_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    hs        = (state_q == ST_RUN) && arr_drv_ready_ip;

    case (state_q)
      ST_IDLE: begin
        if (arr_drv_start_ip) begin
          mode_d    = arr_drv_mode_ip;
          count_d   = arr_drv_count_ip;
          inj_en_d  = arr_drv_inject_en_ip;
          inj_d     = arr_drv_inject_ip;
          idx_d     = '0;
          sent_d    = '0;
          pos_d     = '0;
          lfsr_load = 1'b1;
          sig0_d    = pattern(arr_drv_mode_ip, '0, '0, LFSR_SEED);
          sig1_d    = sig0_d ^ LENGTH'(arr_drv_inject_en_ip && (arr_drv_inject_ip == '0));
          state_d   = (arr_drv_count_ip == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          idx_d    = idx_q + CNT_W'(1);
          sent_d   = sent_q + CNT_W'(1);
          lfsr_adv = 1'b1;
          if (idx_q == count_q - CNT_W'(1)) begin
            // Last vector: the outputs keep it while valid drops.
            state_d = ST_DONE;
          end else begin
            pos_d  = (pos_q == 8'(LENGTH - 1)) ? 8'd0 : pos_q + 8'd1;
            sig0_d = pattern(mode_q, idx_d, pos_d, lfsr_next);
            sig1_d = sig0_d ^ LENGTH'(inj_en_q && (idx_d == inj_q));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge arr_drv_clk_ip) begin
    if (arr_drv_rst_ip) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNT;
      count_q  <= '0;
      inj_en_q <= 1'b0;
      inj_q    <= '0;
      idx_q    <= '0;
      sent_q   <= '0;
      pos_q    <= '0;
      sig0_q   <= '0;
      sig1_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      inj_en_q <= inj_en_d;
      inj_q    <= inj_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
      pos_q    <= pos_d;
      sig0_q   <= sig0_d;
      sig1_q   <= sig1_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign arr_drv_valid_op = valid_q;
  assign arr_drv_sig0_op  = sig0_q;
  assign arr_drv_sig1_op  = sig1_q;
  assign arr_drv_busy_op  = busy_q;
  assign arr_drv_done_op  = done_q;
  assign arr_drv_sent_op  = sent_q;
  assign arr_drv_state_op = state_q;
endmodule
